// File: rtl/simon_pkg.sv
// Shared types and helpers for the colour-sequence game.
//   color_t        : 2-bit colour code (GREEN=0, RED=1, YELLOW=2, BLUE=3)
//   player_state_t : playback engine states
//   PATTERN_DEPTH  : number of entries in the pattern memory
//   color_onehot() : colour code -> one-hot LED vector (bit n for colour n)
package simon_pkg;

  localparam int unsigned PATTERN_DEPTH = 64;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ON,
    ST_OFF,
    ST_DONE
  } player_state_t;

  function automatic logic [3:0] color_onehot(input color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/playback_timer.sv
// Loadable down-counter used for the LED on-time and dark gap.
//   clk, reset  : clock, synchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over decrement)
//   load_val_i  : value to load
//   dec_i       : decrement by one; holds at zero
//   value_o     : current count
//   zero_o      : count is zero
module playback_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] value_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign value_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/pattern_player.sv
// Playback engine for the stored colour sequence. Reads pattern memory
// entries 0..len-1, lights one colour for ON_CYCLES, goes dark for
// OFF_CYCLES, and pulses done at the end.
//   clk       : clock (rising edge)
//   reset     : synchronous, active-high
//   abort     : (only with PATTERN_PLAYER_ABORT_EN) cancel playback
//   start     : begin playback, sampled in IDLE only
//   seq_len   : entries to play, 0..64, larger values clamp to 64
//   mem_addr  : pattern memory read address (asynchronous-read memory)
//   mem_data  : colour at mem_addr, same cycle
//   led       : one-hot colour, 0 when dark
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse at completion
// Optional feature macro: PATTERN_PLAYER_ABORT_EN adds the abort input.
module pattern_player
  import simon_pkg::*;
#(
  parameter int unsigned ADDR_W     = $clog2(PATTERN_DEPTH),
  parameter int unsigned ON_CYCLES  = 25_000_000,
  parameter int unsigned OFF_CYCLES = 12_500_000
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PATTERN_PLAYER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              start,
  input  logic [ADDR_W:0]   seq_len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_data,
  output logic [3:0]        led,
  output logic              busy,
  output logic              done
);

  localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // Keep at least one bit so ON_CYCLES=OFF_CYCLES=1 still elaborates.
  localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  player_state_t   state_q;
  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] len_d;
  logic [3:0]      led_q;
  logic            busy_q;
  logic            done_q;

  logic            tmr_load;
  logic [TW-1:0]   tmr_load_val;
  logic            tmr_dec;
  logic [TW-1:0]   tmr_value;
  logic            tmr_zero;

  assign len_d = (seq_len > DEPTH_LEN) ? DEPTH_LEN : seq_len;

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = ON_LOAD;
    tmr_dec      = 1'b0;
    case (state_q)
      ST_FETCH: tmr_load = 1'b1;
      ST_ON: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = OFF_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_OFF:  tmr_dec = 1'b1;
      default: ;
    endcase
  end

  playback_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_load_val),
    .dec_i     (tmr_dec),
    .value_o   (tmr_value),
    .zero_o    (tmr_zero)
  );

  zero_flag_consistent: assert property (@(posedge clk) disable iff (reset)
    tmr_zero == (tmr_value == '0));

  // led_q doubles as the colour register: the colour is captured
  // straight into one-hot form in FETCH and held through ON.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
`ifdef PATTERN_PLAYER_ABORT_EN
      if (abort && (state_q != ST_IDLE)) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
        led_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
`else
      begin
`endif
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              len_q  <= len_d;
              idx_q  <= '0;
              busy_q <= 1'b1;
              if (len_d == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            led_q   <= color_onehot(color_t'(mem_data));
            state_q <= ST_ON;
          end
          ST_ON: begin
            if (tmr_zero) begin
              led_q   <= '0;
              state_q <= ST_OFF;
            end
          end
          ST_OFF: begin
            if (tmr_zero) begin
              if (idx_q == len_q - 1'b1) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= ST_FETCH;
              end
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr = idx_q[ADDR_W-1:0];
  assign led      = led_q;
  assign busy     = busy_q;
`ifdef PATTERN_PLAYER_ABORT_EN
  // done is registered on entry to DONE, so an abort seen during the
  // DONE cycle masks the already-raised pulse combinationally.
  assign done = done_q & ~abort;
`else
  assign done = done_q;
`endif

endmodule

// File: tb/tb_pattern_player.sv
module tb_pattern_player;

  localparam int AW  = 6;
  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int P   = ON + OFF + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_data;
  logic [3:0]    led;
  logic          busy;
  logic          done;
`ifdef PATTERN_PLAYER_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [1:0] mem [64];
  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  pattern_player #(
    .ADDR_W    (AW),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef PATTERN_PLAYER_ABORT_EN
    .abort   (abort),
`endif
    .start   (start),
    .seq_len (seq_len),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_ph is the number of the cycle now in progress,
  // counted from the edge that accepted start (-1 when idle).
  int   m_ph = -1;
  int   m_len = 0;
  logic m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_ph    = -1;
      m_valid = 1'b1;
    end
`ifdef PATTERN_PLAYER_ABORT_EN
    else if (abort && m_ph >= 0) m_ph = -1;
`endif
    else if (m_ph >= 0) m_ph = (m_ph == m_len * P + 1) ? -1 : m_ph + 1;
    else if (start) begin
      m_len = (int'(seq_len) > 64) ? 64 : int'(seq_len);
      m_ph  = 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0] e_led;
    logic       e_busy;
    logic       e_done;
    int         e_addr;
    int         j;
    int         r;
    if (m_valid) begin
      e_led = '0; e_busy = 1'b0; e_done = 1'b0; e_addr = 0;
      if (m_ph >= 0) begin
        e_busy = 1'b1;
        if (m_ph <= m_len * P) begin
          j = (m_ph - 1) / P;
          r = (m_ph - 1) % P;
          e_addr = j;
          if (r >= 1 && r <= ON) e_led = 4'b0001 << mem[j];
        end else begin
          e_done = 1'b1;
          e_addr = (m_len > 0) ? m_len - 1 : 0;
        end
      end
`ifdef PATTERN_PLAYER_ABORT_EN
      if (abort) e_done = 1'b0;
`endif
      check("model_led", 32'(led), 32'(e_led));
      check("model_busy", 32'(busy), 32'(e_busy));
      check("model_done", 32'(done), 32'(e_done));
      check("model_addr", 32'(mem_addr), 32'(e_addr));
    end
  end

  task automatic load_mem3();
    foreach (mem[i]) mem[i] = 2'd0;
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
  endtask

  // Drive start for the next edge (E0); the caller's loop then begins at cycle 1.
  task automatic arm_start(input int len);
    @(posedge clk); #1;
    seq_len = 7'(len);
    start   = 1'b1;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (m_ph >= 0 && w < 600) begin
      @(posedge clk); #1;
      w++;
    end
    if (m_ph >= 0) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: got busy, expected idle within 600 cycles");
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish by 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic saw_done;
    logic wrapped;
    int   pulses;
    int   len;
    int   ncyc;
    logic [AW-1:0] prev_addr;

    foreach (mem[i]) mem[i] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // Basic 3-entry playback.
    load_mem3();
    arm_start(3);
    for (int c = 1; c <= 23; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (c == 1)  check("s1_busy_c1", 32'(busy), 32'd1);
      if (c == 2)  check("s1_led_c2", 32'(led), 32'b0100);
      if (c == 6)  check("s1_led_c6", 32'(led), 32'b0000);
      if (c == 9)  check("s1_led_c9", 32'(led), 32'b0001);
      if (c == 8)  check("s1_addr_c8", 32'(mem_addr), 32'd1);
      if (c == 15) check("s1_addr_c15", 32'(mem_addr), 32'd2);
      if (c == 16) check("s1_led_c16", 32'(led), 32'b1000);
      if (c == 21) check("s1_done_c21", 32'(done), 32'd0);
      if (c == 22) check("s1_done_c22", 32'(done), 32'd1);
      if (c == 23) check("s1_busy_c23", 32'(busy), 32'd0);
    end

    // Zero-length playback.
    arm_start(0);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (c == 1) begin
        check("s0_done_c1", 32'(done), 32'd1);
        check("s0_busy_c1", 32'(busy), 32'd1);
        check("s0_led_c1", 32'(led), 32'd0);
      end
      if (c == 2) check("s0_busy_c2", 32'(busy), 32'd0);
    end

    // Full 64-entry playback, seq_len above range clamps to 64.
    foreach (mem[i]) mem[i] = 2'd1;
    arm_start(100);
    wrapped = 1'b0; pulses = 0; prev_addr = '0;
    for (int c = 1; c <= 450; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 448 && mem_addr < prev_addr) wrapped = 1'b1;
      if (led == 4'b0010 && (c - 1) % P == 1) pulses++;
      prev_addr = mem_addr;
      if (c == 448) check("s64_addr_c448", 32'(mem_addr), 32'd63);
      if (c == 449) check("s64_done_c449", 32'(done), 32'd1);
    end
    check("s64_nowrap", 32'(wrapped), 32'd0);
    check("s64_pulses", 32'(pulses), 32'd64);

    // start re-asserted and seq_len changed mid-run.
    load_mem3();
    arm_start(3);
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c >= 3 && c < 12) begin
        start   = 1'b1;
        seq_len = 7'd5;
      end
      @(negedge clk);
      if (c == 22) check("srs_done_c22", 32'(done), 32'd1);
      if (c == 23) check("srs_busy_c23", 32'(busy), 32'd0);
    end

    // Reset during ON of entry 1, then a fresh replay.
    arm_start(3);
    saw_done = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      reset = (c == 9);
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (c == 10) begin
        check("srst_led", 32'(led), 32'd0);
        check("srst_busy", 32'(busy), 32'd0);
        check("srst_addr", 32'(mem_addr), 32'd0);
      end
    end
    check("srst_no_done", 32'(saw_done), 32'd0);
    arm_start(3);
    for (int c = 1; c <= 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (c == 1) check("srst_replay_addr", 32'(mem_addr), 32'd0);
      if (c == 2) check("srst_replay_led", 32'(led), 32'b0100);
    end
    wait_idle();

`ifdef PATTERN_PLAYER_ABORT_EN
    // Abort during OFF of entry 0.
    arm_start(3);
    saw_done = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (c == 6);
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (c == 7) check("sab_busy_c7", 32'(busy), 32'd0);
    end
    check("sab_no_done", 32'(saw_done), 32'd0);
    // Abort in the DONE cycle of a one-entry run (done would be cycle 8).
    arm_start(1);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (c == 8);
      @(negedge clk);
      if (c == 8) check("sab_done_c8", 32'(done), 32'd0);
      if (c == 9) check("sab_busy_c9", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    abort = 1'b0;
`endif

    // Randomised runs with start/seq_len noise and occasional reset.
    for (int r = 0; r < 30; r++) begin
      start = 1'b0;
      reset = 1'b0;
`ifdef PATTERN_PLAYER_ABORT_EN
      abort = 1'b0;
`endif
      wait_idle();
      foreach (mem[i]) mem[i] = 2'($urandom);
      len = (r % 10 == 9) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 8));
      seq_len = 7'(len);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ncyc = ((len > 64) ? 64 : len) * P + 3;
      for (int c = 0; c < ncyc; c++) begin
        start   = ($urandom_range(0, 5) == 0);
        seq_len = 7'($urandom_range(0, 127));
        reset   = ($urandom_range(0, 199) == 0);
`ifdef PATTERN_PLAYER_ABORT_EN
        abort   = ($urandom_range(0, 59) == 0);
`endif
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    reset = 1'b0;
`ifdef PATTERN_PLAYER_ABORT_EN
    abort = 1'b0;
`endif
    wait_idle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
# pattern_player

Playback engine for the stored colour sequence: reads the pattern memory from address 0 up to `seq_len-1`, lights one colour LED per entry for a fixed on-time followed by a dark gap, then pulses `done`. It is the read/consume side of the pattern memory. It sits between the game controller, which issues `start` and `seq_len`, and the LED driver. It owns the memory read address whenever `busy` is high.

## Interface
- `ADDR_W`, 6: pattern memory address width (64 entries).
- `ON_CYCLES`, 25_000_000: clock cycles each colour is lit, ≥1.
- `OFF_CYCLES`, 12_500_000: dark gap after each colour, ≥1.
- `clk  in  1`: single clock; all logic on rising edge.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: begin playback; sampled only in IDLE.
- `seq_len  in  ADDR_W+1`: number of entries to play, 0..64; values >64 clamp to 64.
- `mem_addr  out  ADDR_W`: read address into pattern memory, which has an asynchronous read.
- `mem_data  in  2`: colour at `mem_addr`, valid in the same cycle.
- `led  out  4`: one-hot colour output; bit n lit for colour n; 0 when dark.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: single-cycle pulse when playback completes.

## Operation
- States: IDLE, FETCH, ON, OFF, DONE.
- **IDLE**
  - `led`=0, `busy`=0.
  - `start`=1 latches the clamped `seq_len` and sets idx=0.
  - If the length is 0, go to DONE; otherwise go to FETCH.
- **FETCH** (1 cycle)
  - `mem_addr`=idx.
  - Capture `mem_data` into the colour register.
  - Load the timer with ON_CYCLES-1 and go to ON.
- **ON**
  - `led`=onehot(colour).
  - Timer decrements each cycle.
  - At 0, load the timer with OFF_CYCLES-1 and go to OFF.
- **OFF**
  - `led`=0.
  - At timer 0: if idx==len-1, go to DONE; else idx+1 and go to FETCH.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored. `seq_len` changes after latch are ignored.
- `mem_addr` holds idx in all states. It is 0 in IDLE.
- idx is ADDR_W+1 bits so len=64 terminates without wrap. `mem_addr` is idx[ADDR_W-1:0].
- Reset mid-playback forces IDLE next edge and drops any lit LED.

## Timing
- Reset values: `led`=0, `busy`=0, `done`=0, `mem_addr`=0. Internal state is IDLE, idx=0, timer=0.
- Cycle numbering: `start` is sampled at edge E0, and cycle 1 follows E0.
- Per entry: 1 FETCH + ON_CYCLES lit + OFF_CYCLES dark.
- `done` is high in cycle len·(1+ON_CYCLES+OFF_CYCLES)+1.
- For len=0, `done` is high in cycle 1.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- `start` held high through DONE does not start a new playback until the state is IDLE. The earliest re-trigger is sampled in the first IDLE cycle.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)).

## Configuration
- Macro: `PATTERN_PLAYER_ABORT_EN`.
- **Defined**:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in any non-IDLE state forces IDLE at the next edge, with `led`=0 and no `done` pulse.
  - `abort` has priority over all normal transitions, including DONE→IDLE, which suppresses that pulse.
  - In IDLE, `abort` is ignored and takes priority over nothing.
- **Undefined**: port absent; playback always runs to completion or reset.

## Structure
- Shared package `simon_pkg`:
  - `color_t`: 2-bit enum with GREEN=0, RED=1, YELLOW=2, BLUE=3.
  - `player_state_t` enum.
  - `PATTERN_DEPTH`=64 constant.
  - `color_onehot()` function.
- One sub-module, `playback_timer`: loadable down-counter with `load`, `value` and `zero` outputs, parameterised by width.
- The FSM and idx register live in `pattern_player`.

## Test plan
All scenarios use ON_CYCLES=4 and OFF_CYCLES=2.
- Memory [2,0,3], `seq_len`=3, `start` pulse:
  - `led` reads 0100×4, 0×2, 0001×4, 0×2, 1000×4, 0×2.
  - `done` is high in cycle 22.
  - `mem_addr` steps 0,1,2.
- `seq_len`=0 with `start` → `done` in cycle 1, `led` stays 0, `busy` high for exactly 1 cycle.
- `seq_len`=64 with all memory =1 → 64 LED pulses of 0010, `done` in cycle 449, `mem_addr` ends at 63 with no wrap to 0 beforehand.
- `start` re-asserted during ON and `seq_len` changed mid-run → no restart and no length change; `done` occurs at the originally computed cycle.
- `reset` asserted during ON of entry 1 → `led`=0, `busy`=0, `mem_addr`=0 after that edge; no `done`; a new `start` replays from address 0.
- With `PATTERN_PLAYER_ABORT_EN`: `abort` during OFF → IDLE next cycle, no `done`; `abort` in the DONE cycle suppresses the pulse.
